uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter WORD_WIDTH, default 8, data bits per frame.
REQ-002 Parameter OVERSAMPLING, default 16, baud ticks per bit period.
REQ-003 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-004 Clock: i_clk  input  1  system clock, frequency given by the platform macro SYSFREQ (Hz).
REQ-005 Reset: i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_wr_valid  input  1  write request, word on i_wr_data is valid.
REQ-007 Port i_wr_data  input  WORD_WIDTH  word to transmit.
REQ-008 Port o_wr_ready  output  1  transmitter can accept a word.
REQ-009 Port o_dout  output  1  serial line, idle high.
REQ-010 Port o_busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-011 Internal tick divider SHALL be DIV = SYSFREQ/(BAUD_RATE*OVERSAMPLING), integer division with minimum 1; one tick is a single-cycle pulse every DIV clocks.
REQ-012 One bit period SHALL be exactly OVERSAMPLING ticks, i.e. DIV*OVERSAMPLING clocks.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; o_dout is 1 in IDLE, 0 in START, the current data bit in DATA, the parity bit in PARITY, and 1 in STOP.
REQ-014 o_wr_ready SHALL be high only in IDLE; a word is accepted on a clock where i_wr_valid && o_wr_ready.
REQ-015 On acceptance the block SHALL capture i_wr_data into a shift register, clear the tick divider and the bit-period counter, and enter START on the next clock edge, so o_dout falls the clock after acceptance.
REQ-016 Changes on i_wr_data or i_wr_valid while not in IDLE SHALL have no effect.
REQ-017 DATA SHALL send WORD_WIDTH bits LSB first, one per bit period; the bit index counter wraps to 0 on exit from DATA.
REQ-018 After DATA the state SHALL go to PARITY if parity is compiled in, else STOP; PARITY goes to STOP after one bit period.
REQ-019 STOP SHALL last one bit period and then return to IDLE; o_wr_ready rises on the clock IDLE is entered.
REQ-020 With i_wr_valid held high, consecutive frames SHALL be separated by exactly one idle clock (o_dout high, o_wr_ready high).
REQ-021 State transitions SHALL occur only at a bit-period boundary (the last tick of the period), except the IDLE->START transition on acceptance.
REQ-022 o_dout SHALL be driven from a register (glitch-free).

Reset
REQ-023 Reset assertion SHALL act immediately at any time, including mid-frame: state IDLE, o_dout=1, o_wr_ready=1, o_busy=0, all counters and the shift register 0.
REQ-024 After reset deassertion, the first accepted word SHALL produce a complete, correctly timed frame.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: PARITY state compiled in; parity bit = ~(^word) (odd parity); frame = start + WORD_WIDTH + parity + stop bit periods.
REQ-026 UART_TX_PARITY_EN undefined: no PARITY state or parity logic; frame = start + WORD_WIDTH + stop bit periods.

Verification (SYSFREQ=18432000, defaults -> DIV=10, bit period = 160 clocks)
REQ-027 Write 0x55, parity off -> o_dout low 160 clocks, then 1,0,1,0,1,0,1,0 at 160 clocks each, then high 160 clocks; o_wr_ready returns high 1600 clocks after the first low clock.
REQ-028 Write 0x03 with UART_TX_PARITY_EN -> data bits 1,1,0,0,0,0,0,0, parity bit 1, stop 1; frame = 1760 clocks.
REQ-029 Write 0xA5 then 0x3C with i_wr_valid held high -> two correct frames with exactly one clock of o_dout high between the stop bit and the next start bit.
REQ-030 Assert i_rst_n low during DATA bit 3 of 0xFF -> o_dout=1, o_busy=0, o_wr_ready=1 in the same cycle; after release, write 0x0F -> full correct frame.
REQ-031 Change i_wr_data from 0x12 to 0xEE mid-frame with i_wr_valid high -> the line still carries 0x12; 0xEE is sent only after o_wr_ready reasserts.
REQ-032 i_wr_valid low for 5000 clocks after reset -> o_dout stays 1, o_busy stays 0, o_wr_ready stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start, WORD_WIDTH data bits LSB first, optional odd parity, one stop bit.
// Optional parity bit is compiled in by defining UART_TX_PARITY_EN; SYSFREQ gives the clock in Hz.
`ifndef SYSFREQ
`define SYSFREQ 18432000
`endif

module uart_tx #(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUD_RATE    = 115200
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_dout,
  output logic                  o_busy
);

  localparam int DIV_RAW = `SYSFREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int IDX_W   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [OS_W-1:0]       os_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] shifted;
  logic                  dout;
  logic                  tick;
  logic                  period_end;
  logic                  accept;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
`endif

  // Counters are held at zero in IDLE, so every frame starts on a fresh bit period.
  assign tick       = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
  assign period_end = tick && (os_cnt == OS_W'(OVERSAMPLING - 1));
  assign accept     = i_wr_valid && (state == IDLE);
  assign shifted    = shreg >> 1;

  assign o_wr_ready = (state == IDLE);
  assign o_busy     = (state != IDLE);
  assign o_dout     = dout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      dout    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      if (accept) begin
        shreg <= i_wr_data;
        state <= START;
        dout  <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity <= ~(^i_wr_data);
`endif
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        os_cnt <= period_end ? '0 : os_cnt + 1'b1;
      end
      // The line register is loaded with the value of the state being entered.
      if (period_end) begin
        case (state)
          START: begin
            state <= DATA;
            dout  <= shreg[0];
          end
          DATA: begin
            shreg <= shifted;
            if (bit_idx == IDX_W'(WORD_WIDTH - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              dout    <= parity;
`else
              state   <= STOP;
              dout    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              dout    <= shifted[0];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            dout  <= 1'b1;
          end
`endif
          STOP: begin
            state <= IDLE;
            dout  <= 1'b1;
          end
          default: begin
            state <= IDLE;
            dout  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
